// File: rtl/keypad_pkg.sv
// Shared scan-FSM states, width helper and the 4x4 PMOD legend for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_DRIVE,
        S_EVAL,
        S_EMIT
    } scan_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Key index r*4+c to the printed legend of the 4x4 PMOD keypad.
    localparam logic [3:0] HEX_MAP_4X4 [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event FIFO; a write is visible at the head one cycle later.
// A write into a full FIFO is taken only when the head is popped in the same cycle.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    last_idx;
    logic             pop;
    logic             wr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop      = out_rdy && !empty;
    assign wr       = in_vld && (!full || pop);
    assign last_idx = rd_ptr[AW-1:0] - 1'b1;

    // While empty, show the most recently popped slot so the outputs hold.
    assign out_dat = empty ? mem[last_idx] : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr[AW-1:0]] <= in_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner_pro.sv
// Scans a ROWS x COLS matrix, debounces per key, queues press/release/repeat events.
// Events appear N+2 cycles after a frame ends at most; a full FIFO drops new events with an overflow pulse.
module keypad_scanner_pro
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CLK_HZ          = 100_000_000,
    parameter int COL_US          = 1000,
    parameter int SETTLE_CYCLES   = 100,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPORT_RELEASE  = 1,
    parameter int REPEAT_DELAY    = 125,
    parameter int REPEAT_PERIOD   = 25,
    localparam int KEY_W          = clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    input  logic                 rpt_en,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [KEY_W-1:0]     ev_code,
    output logic                 ev_press,
    output logic                 ev_repeat,
    output logic [ROWS*COLS-1:0] key_down,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int N         = ROWS * COLS;
    localparam int COL_TICKS = CLK_HZ / 1_000_000 * COL_US;
    localparam int TICK_W    = clog2(COL_TICKS);
    localparam int CIDX_W    = clog2(COLS);
    localparam int CNT_W     = clog2(DEBOUNCE_FRAMES + 1);
    localparam int RPT_W     = clog2(REPEAT_DELAY + REPEAT_PERIOD + 2);
    localparam int EIDX_W    = KEY_W + 1;
    localparam int EV_W      = KEY_W + 2;

    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_sync;
    logic [TICK_W-1:0] tick;
    logic [CIDX_W-1:0] cidx;
    logic [N-1:0]      raw;
    logic              tick_last;
    logic              frame_end;

    scan_state_t       state;
    scan_state_t       state_nx;
    logic [EIDX_W-1:0] emit_idx;
    logic [KEY_W-1:0]  emit_key;
    logic [CNT_W-1:0]  cnt [N];
    logic [N-1:0]      pend;
    logic              changed;

    logic [RPT_W-1:0]  rpt_cnt;
    logic              rpt_ph2;
    logic [RPT_W-1:0]  rpt_target;
    logic              held_one;
    logic              rpt_fire;
    logic [KEY_W-1:0]  held_key;

    logic              push;
    logic [KEY_W-1:0]  push_code;
    logic              push_press;
    logic              push_rpt;
    logic [EV_W-1:0]   fifo_dat;
    logic              fifo_full;
    logic              fifo_empty;

    assign tick_last = (tick == TICK_W'(COL_TICKS - 1));
    assign frame_end = tick_last && (cidx == CIDX_W'(COLS - 1));
    assign emit_key  = emit_idx[KEY_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // The column scan free-runs; evaluation and emission never stall it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= '0;
            cidx       <= '0;
            col        <= '1;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tick_last) begin
                tick <= '0;
                cidx <= (cidx == CIDX_W'(COLS - 1)) ? '0 : cidx + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
            if (tick == '0) col <= ~(COLS'(1) << cidx);
            if (tick == TICK_W'(SETTLE_CYCLES)) begin
                for (int c = 0; c < COLS; c++) begin
                    if (cidx == CIDX_W'(c)) begin
                        for (int r = 0; r < ROWS; r++) raw[r*COLS + c] <= ~row_sync[r];
                    end
                end
            end
        end
    end

    always_comb begin
        held_key = '0;
        for (int k = 0; k < N; k++) begin
            if (key_down[k]) held_key = KEY_W'(k);
        end
    end

    assign held_one   = rpt_en && ($countones(key_down) == 1);
    assign rpt_target = rpt_ph2 ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
    assign rpt_fire   = held_one && !changed && (rpt_cnt == rpt_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_DRIVE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        push       = 1'b0;
        push_code  = '0;
        push_press = 1'b0;
        push_rpt   = 1'b0;
        case (state)
            S_DRIVE: if (frame_end) state_nx = S_EVAL;
            S_EVAL:  state_nx = S_EMIT;
            S_EMIT: begin
                // Slot N after the key walk carries the auto-repeat event.
                if (emit_idx == EIDX_W'(N)) begin
                    state_nx = S_DRIVE;
                    if (rpt_fire) begin
                        push       = 1'b1;
                        push_code  = held_key;
                        push_press = 1'b1;
                        push_rpt   = 1'b1;
                    end
                end else if (pend[emit_key]) begin
                    push       = key_down[emit_key] || (REPORT_RELEASE != 0);
                    push_code  = emit_key;
                    push_press = key_down[emit_key];
                end
            end
            default: state_nx = S_DRIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down <= '0;
            pend     <= '0;
            changed  <= 1'b0;
            emit_idx <= '0;
            rpt_cnt  <= '0;
            rpt_ph2  <= 1'b0;
            for (int k = 0; k < N; k++) cnt[k] <= '0;
        end else begin
            case (state)
                S_EVAL: begin
                    emit_idx <= '0;
                    changed  <= 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (raw[k] != key_down[k]) begin
                            if (cnt[k] == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                                key_down[k] <= ~key_down[k];
                                cnt[k]      <= '0;
                                pend[k]     <= 1'b1;
                                changed     <= 1'b1;
                            end else begin
                                cnt[k] <= cnt[k] + 1'b1;
                            end
                        end else begin
                            cnt[k] <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (emit_idx == EIDX_W'(N)) begin
                        emit_idx <= '0;
                        // A frame that changed the key set counts as frame 0 of the hold.
                        if (!held_one) begin
                            rpt_cnt <= '0;
                            rpt_ph2 <= 1'b0;
                        end else if (changed) begin
                            rpt_cnt <= RPT_W'(1);
                            rpt_ph2 <= 1'b0;
                        end else if (rpt_cnt == rpt_target) begin
                            rpt_cnt <= RPT_W'(1);
                            rpt_ph2 <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end else begin
                        pend[emit_key] <= 1'b0;
                        emit_idx       <= emit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= push && fifo_full && !ev_ready;
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (push),
        .in_dat  ({push_code, push_press, push_rpt}),
        .out_rdy (ev_ready),
        .out_dat (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign {ev_code, ev_press, ev_repeat} = fifo_dat;

endmodule

// File: doc/keypad_scanner_pro.md
Name: keypad_scanner_pro

Overview:
- Parametrised successor to the 4x4 PMOD keypad scanner.
- Scans any ROWS x COLS matrix with active-low column drive and active-low row sense.
- Debounces each key independently and reports press/release events through a small FIFO with a valid/ready handshake.
- Adds optional auto-repeat. Sits between the PMOD pins and the lab's control/display logic.

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- CLK_HZ, 100_000_000, clk frequency in Hz
- COL_US, 1000, time each column is driven, in µs
- SETTLE_CYCLES, 100, cycles from column drive to row sample; must be < COL_TICKS-1
- DEBOUNCE_FRAMES, 3, consecutive agreeing frames before a key's stable state changes (>=1)
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
- REPORT_RELEASE, 1, 1 = queue release events, 0 = press events only
- REPEAT_DELAY, 125, frames a sole held key waits before the first repeat
- REPEAT_PERIOD, 25, frames between subsequent repeats

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  row sense, active low, asynchronous to clk
- col  out  COLS  column drive, exactly one bit low while scanning
- rpt_en  in  1  auto-repeat enable, level
- ev_valid  out  1  event available at FIFO head
- ev_ready  in  1  consumer accepts head event when ev_valid & ev_ready
- ev_code  out  KEY_W  key index = r*COLS + c, where KEY_W = clog2(ROWS*COLS)
- ev_press  out  1  1 = press or repeat, 0 = release
- ev_repeat  out  1  1 = auto-repeat event
- key_down  out  ROWS*COLS  debounced stable state bitmap
- frame_done  out  1  one-cycle pulse at the end of each full scan
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset: col = all ones, ev_valid = 0, ev_code/ev_press/ev_repeat = 0, key_down = 0, frame_done = 0, overflow = 0. All counters, FIFO pointers and debounce state are cleared. Reset is honoured mid-scan and mid-drain; any pending events are lost.
- row passes through a 2-flop synchronizer before use.
- Timing: COL_TICKS = CLK_HZ/1_000_000*COL_US. Tick counter runs 0..COL_TICKS-1 per column.
- Scan FSM, state S_DRIVE, runs per column:
  - tick 0: col = ~(1<<c).
  - tick SETTLE_CYCLES: raw[r*COLS+c] = ~row_sync[r] for every row.
  - tick COL_TICKS-1: advance c.
  - After c = COLS-1: c wraps to 0, frame_done pulses, FSM moves to S_EVAL.
- Columns drive continuously, including during S_EVAL and S_EMIT; the scan is never stalled.
- S_EVAL, one cycle: for each key k:
  - If raw[k] != key_down[k], cnt[k]++; otherwise cnt[k] = 0.
  - When cnt[k] reaches DEBOUNCE_FRAMES, key_down[k] toggles, cnt[k] = 0, and pend[k] is set.
- S_EMIT: walks k = 0..N-1, one key per cycle, then returns to S_DRIVE bookkeeping.
  - For each k with pend[k]: push {k, press = key_down[k]}. Release events are skipped if REPORT_RELEASE = 0.
  - The walk costs N cycles, far shorter than one column period.
- Auto-repeat (rpt_en = 1 and exactly one key_down bit set):
  - A frame counter starts at 0 on that key's press.
  - At REPEAT_DELAY, then every REPEAT_PERIOD frames, push {k, press = 1, repeat = 1} at the end of S_EMIT.
  - The counter clears if the held-key count != 1 or rpt_en = 0.
- FIFO behaviour:
  - Push is first-word-fall-through: an event is visible on ev_* the cycle after it is pushed.
  - Pop when ev_valid & ev_ready.
  - Full FIFO with simultaneous pop and push: both are accepted.
  - Full FIFO without a pop: push is dropped and overflow pulses; the earlier entries are kept.
  - Empty FIFO: ev_valid = 0 and ev_* hold their last values.
- Multiple keys changing in the same frame are emitted in ascending index order.
- Ghosting is not suppressed; the raw matrix is reported as sampled.

Decomposition:
- Package keypad_pkg holds:
  - scan FSM state enum S_DRIVE/S_EVAL/S_EMIT;
  - clog2 function;
  - HEX_MAP_4X4 constant mapping index to hex legend: 1,2,3,A / 4,5,6,B / 7,8,9,C / 0,F,E,D.
- One sub-module: keypad_event_fifo, a parametrised depth/width FWFT FIFO with full/empty and push/pop handshake.

Test Plan:
Bench setup: CLK_HZ = 1_000_000, COL_US = 20 (COL_TICKS = 20), SETTLE_CYCLES = 3, DEBOUNCE_FRAMES = 2.
- Reset mid-scan: assert rst_n low at tick 7 of column 2 -> col = 4'b1111, ev_valid = 0, key_down = 0 while low. First col = 4'b1110 occurs 1 cycle after release.
- Press key r1,c2: hold row = 4'b1101 whenever col = 4'b1011 for 3 frames -> key_down[6] set after the 2nd frame's S_EVAL. One event ev_code = 6, ev_press = 1, ev_repeat = 0. No release until row returns high for 2 frames, then ev_code = 6, ev_press = 0.
- Bounce: key 5 alternates pressed/released every frame -> no event and key_down[5] stays 0.
- Simultaneous presses: keys 3 and 9 debounce in the same frame -> events popped in order 3 then 9.
- Overflow: FIFO_DEPTH = 4, ev_ready = 0, 5 press events -> 4 queued, overflow pulses once. Pops return the first 4 in order.
- Auto-repeat: REPEAT_DELAY = 4, REPEAT_PERIOD = 2, rpt_en = 1, key 0 held -> press event, then repeat events at frames +4, +6, +8. A second key held stops the repeats.
